// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: merges an instruction and a data SRAM-like request port
// onto one downstream SRAM-like port, and routes completions back in order.
//
// Optional build macro: ARB_RR_EN selects round-robin arbitration between
// the two requesters. When it is undefined, data has fixed priority over
// instruction.
//
// Ports:
//   aclk, aresetn                    clock, asynchronous active-low reset
//   inst_req/inst_addr               instruction read request (size 2)
//   inst_addr_ok/inst_data_ok        instruction accept / completion strobes
//   inst_rdata                       instruction read data
//   data_req/wr/size/addr/wstrb/wdata  data request
//   data_addr_ok/data_data_ok        data accept / completion strobes
//   data_rdata                       data read data
//   m_req/wr/size/addr/wstrb/wdata   downstream request (mux of the granted side)
//   m_addr_ok/m_data_ok/m_rdata      downstream accept, completion, read data
module sram_req_arbiter #(
    parameter int unsigned OST_DEPTH = 4
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int unsigned PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Grant lock: held while the granted request waits for m_addr_ok.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } lock_state_e;

    lock_state_e       state_q;
    lock_state_e       state_d;

    logic [OST_DEPTH-1:0] tag_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    logic gnt_data;
    logic pri_data;
    logic req_sel;
    logic full;
    logic accept;
    logic pop;
    logic head;

    // Which side wins when both request and no lock is held.
`ifdef ARB_RR_EN
    logic rr_data_first_q;

    assign pri_data = data_req & (~inst_req | rr_data_first_q);

    // After every accepted grant the other side gets priority next time.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_data_first_q <= 1'b1;
        end else if (accept) begin
            rr_data_first_q <= ~gnt_data;
        end
    end
`else
    assign pri_data = data_req;
`endif

    assign full = (count_q == CNT_W'(OST_DEPTH));

    // Lock state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection and lock next-state.
    always_comb begin
        state_d  = state_q;
        gnt_data = 1'b0;
        req_sel  = 1'b0;
        case (state_q)
            ST_LOCK_INST: gnt_data = 1'b0;
            ST_LOCK_DATA: gnt_data = 1'b1;
            default:      gnt_data = pri_data;
        endcase
        req_sel = gnt_data ? data_req : inst_req;
        // A full tag FIFO suppresses m_req, so a pending lock simply persists.
        if (aresetn && !full && req_sel) begin
            if (m_addr_ok) begin
                state_d = ST_IDLE;
            end else begin
                state_d = gnt_data ? ST_LOCK_DATA : ST_LOCK_INST;
            end
        end
    end

    // Reset gates m_req so all strobes are low while aresetn is asserted.
    assign m_req   = aresetn & ~full & req_sel;
    assign m_wr    = gnt_data & data_wr;
    assign m_size  = gnt_data ? data_size  : 2'd2;
    assign m_addr  = gnt_data ? data_addr  : inst_addr;
    assign m_wstrb = gnt_data ? data_wstrb : 4'd0;
    assign m_wdata = gnt_data ? data_wdata : 32'd0;

    assign accept       = m_req & m_addr_ok;
    assign inst_addr_ok = accept & ~gnt_data;
    assign data_addr_ok = accept & gnt_data;

    // Responses with no outstanding tag are dropped.
    assign pop  = m_data_ok & (count_q != '0);
    assign head = tag_q[rd_ptr_q];

    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    // Owner tag FIFO (0 = inst, 1 = data); pointers wrap at the power-of-2 depth.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                tag_q[wr_ptr_q] <= gnt_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbiter rules.
module tb_sram_req_arbiter;

    localparam int DEPTH = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [31:0] data_addr = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_addr_ok = 1'b0;
    logic        m_data_ok = 1'b0;
    logic [31:0] m_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: outstanding owners in order, lock owner, RR priority.
    bit mq[$];
    int lock_own = -1;
    bit prio_data = 1'b1;
    int exp_own;
    bit exp_mreq, exp_push, exp_pop, exp_head;
    bit acc_inst, acc_data;

    sram_req_arbiter #(.OST_DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        lock_own  = -1;
        prio_data = 1'b1;
    endtask

    // Expected behaviour for the current inputs and model state.
    task automatic compute_exp();
        int own;
        bit full;
        full = (mq.size() == DEPTH);
        if (lock_own >= 0)             own = lock_own;
        else if (data_req && inst_req) own = RR ? (prio_data ? 1 : 0) : 1;
        else if (data_req)             own = 1;
        else if (inst_req)             own = 0;
        else                           own = -1;
        exp_own  = own;
        exp_mreq = (own >= 0) && !full && ((own == 1) ? data_req : inst_req);
        exp_push = exp_mreq && m_addr_ok;
        exp_pop  = m_data_ok && (mq.size() > 0);
        exp_head = exp_pop ? mq[0] : 1'b0;
    endtask

    // Called at a negedge with inputs driven: compare, clock once, update model.
    task automatic step();
        #1;
        compute_exp();
        check("m_req", 32'(m_req), 32'(exp_mreq));
        if (exp_mreq) begin
            if (exp_own == 1) begin
                check("m_wr",    32'(m_wr),    32'(data_wr));
                check("m_size",  32'(m_size),  32'(data_size));
                check("m_addr",  m_addr,       data_addr);
                check("m_wstrb", 32'(m_wstrb), 32'(data_wstrb));
                check("m_wdata", m_wdata,      data_wdata);
            end else begin
                check("m_wr",    32'(m_wr),    32'(0));
                check("m_size",  32'(m_size),  32'(2));
                check("m_addr",  m_addr,       inst_addr);
                check("m_wstrb", 32'(m_wstrb), 32'(0));
                check("m_wdata", m_wdata,      32'(0));
            end
        end
        check("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_push && exp_own == 0));
        check("data_addr_ok", 32'(data_addr_ok), 32'(exp_push && exp_own == 1));
        check("inst_data_ok", 32'(inst_data_ok), 32'(exp_pop && !exp_head));
        check("data_data_ok", 32'(data_data_ok), 32'(exp_pop && exp_head));
        if (exp_pop) begin
            check("inst_rdata", inst_rdata, m_rdata);
            check("data_rdata", data_rdata, m_rdata);
        end
        acc_inst = exp_push && exp_own == 0;
        acc_data = exp_push && exp_own == 1;
        @(posedge aclk);
        if (exp_pop) void'(mq.pop_front());
        if (exp_push) mq.push_back(exp_own == 1);
        if (exp_mreq && !m_addr_ok) lock_own = exp_own;
        else if (exp_push)          lock_own = -1;
        if (exp_push) prio_data = (exp_own == 0);
        @(negedge aclk);
    endtask

    task automatic idle_inputs();
        inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0;
        data_wr = 0; data_size = 0; data_wstrb = 0;
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        aresetn = 0;
        idle_inputs();
        model_reset();
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1;
    endtask

    initial begin
        idle_inputs();
        inst_addr = 32'h0000_1000;
        data_addr = 32'h0000_2000;
        data_wdata = 32'hCAFE_0000;

        // Reset state.
        #2;
        check("rst_m_req", 32'(m_req), 32'(0));
        check("rst_dok",   32'(data_data_ok | inst_data_ok), 32'(0));
        apply_reset();

        // Constant contention with m_addr_ok every cycle.
        inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("cont_d", 32'(data_addr_ok), RR ? 32'(i % 2 == 0) : 32'(1));
            check("cont_i", 32'(inst_addr_ok), RR ? 32'(i % 2 == 1) : 32'(0));
            step();
        end
        apply_reset();

        // Grant lock: data arriving during an inst wait does not preempt.
        inst_req = 1; inst_addr = 32'h0000_0A00;
        step();
        data_req = 1; data_addr = 32'h0000_0B00;
        for (int i = 1; i < 3; i++) begin
            #1;
            check("lock_addr", m_addr, 32'h0000_0A00);
            step();
        end
        m_addr_ok = 1;
        #1;
        check("lock_i_aok", 32'(inst_addr_ok), 32'(1));
        check("lock_d_aok", 32'(data_addr_ok), 32'(0));
        step();
        inst_req = 0;
        #1;
        check("lock_d_next", 32'(data_addr_ok), 32'(1));
        step();
        apply_reset();

        // Fill to depth D,I,D,I, then drain in order with tagged rdata.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                data_req = (k % 2 == 0); inst_req = (k % 2 == 1);
                m_addr_ok = 1; m_data_ok = 0;
                data_addr = 32'h100 + 32'(k); inst_addr = 32'h200 + 32'(4 * k);
                step();
            end
            data_req = 1; inst_req = 1;
            #1;
            check("full_mreq", 32'(m_req), 32'(0));
            step();
            if (r == 0) begin
                data_req = 0; inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
                for (int k = 0; k < 4; k++) begin
                    m_rdata = 32'h11 * 32'(k + 1);
                    #1;
                    check("drain_dok",  32'(data_data_ok), 32'(k % 2 == 0));
                    check("drain_iok",  32'(inst_data_ok), 32'(k % 2 == 1));
                    check("drain_rd",   (k % 2 == 0) ? data_rdata : inst_rdata, 32'h11 * 32'(k + 1));
                    step();
                end
                m_data_ok = 0;
            end
        end
        // Full with a completion: pop now, request resumes next cycle.
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h55;
        #1;
        check("full_pop_mreq", 32'(m_req), 32'(0));
        check("full_pop_dok",  32'(data_data_ok), 32'(1));
        step();
        #1;
        check("resume_mreq", 32'(m_req), 32'(1));
        step();
        m_addr_ok = 0; m_data_ok = 0;
        #1;
        check("stay3_mreq", 32'(m_req), 32'(1));
        step();
        apply_reset();

        // Asynchronous reset with two outstanding, then a stray response.
        data_req = 1; m_addr_ok = 1;
        step();
        step();
        inst_req = 1; m_data_ok = 1;
        #1;
        check("pre_rst_mreq", 32'(m_req), 32'(1));
        #1;
        aresetn = 0;
        #1;
        check("arst_mreq", 32'(m_req), 32'(0));
        check("arst_aok",  32'(inst_addr_ok | data_addr_ok), 32'(0));
        check("arst_dok",  32'(inst_data_ok | data_data_ok), 32'(0));
        model_reset();
        idle_inputs();
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1;
        m_data_ok = 1;
        #1;
        check("stray_dok", 32'(inst_data_ok | data_data_ok), 32'(0));
        step();
        m_data_ok = 0;

        // Randomized traffic against the reference model.
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if (!inst_req && ($urandom % 2 == 0)) begin
                inst_req  = 1;
                inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_req && ($urandom % 2 == 0)) begin
                data_req   = 1;
                data_wr    = 1'($urandom);
                data_size  = 2'($urandom % 3);
                data_addr  = $urandom;
                data_wstrb = 4'($urandom);
                data_wdata = $urandom;
            end
            m_addr_ok = ($urandom % 4 != 0);
            m_data_ok = 1'($urandom);
            m_rdata   = $urandom;
            step();
            if (acc_inst) inst_req = 0;
            if (acc_data) data_req = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter OST_DEPTH, default 4, giving max outstanding (addr_ok'd, not data_ok'd) transactions; power of 2, at least 2.
REQ-002 SHALL have port aclk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port inst_req  input  1  instruction read request, held until inst_addr_ok.
REQ-005 SHALL have port inst_addr  input  32  instruction word address; size fixed to 2 (4 bytes).
REQ-006 SHALL have port inst_addr_ok  output  1  instruction request accepted this cycle.
REQ-007 SHALL have port inst_data_ok  output  1  instruction read data valid this cycle.
REQ-008 SHALL have port inst_rdata  output  32  instruction read data.
REQ-009 SHALL have port data_req  input  1  data request, held until data_addr_ok.
REQ-010 SHALL have port data_wr  input  1  1 = write, 0 = read.
REQ-011 SHALL have port data_size  input  2  bytes = 2^size.
REQ-012 SHALL have port data_addr  input  32  data address.
REQ-013 SHALL have port data_wstrb  input  4  write byte strobes.
REQ-014 SHALL have port data_wdata  input  32  write data.
REQ-015 SHALL have port data_addr_ok / data_data_ok  output  1 each  data accept / completion strobes.
REQ-016 SHALL have port data_rdata  output  32  data read data.
REQ-017 SHALL have ports m_req, m_wr (1), m_size (2), m_addr (32), m_wstrb (4), m_wdata (32)  output  downstream SRAM-like request toward the AXI bridge.
REQ-018 SHALL have ports m_addr_ok, m_data_ok (1), m_rdata (32)  input  downstream accept, completion, read data.

Function
REQ-019 SHALL grant one requester per cycle; m_* request fields SHALL be a combinational mux of the granted requester; instruction forwards m_wr=0, m_size=2, m_wstrb=0, m_wdata=0.
REQ-020 SHALL default to fixed priority: data over instruction when both request in the same cycle.
REQ-021 SHALL lock the grant once m_req=1 and m_addr_ok=0, until m_addr_ok; a newly arriving higher-priority request SHALL NOT preempt.
REQ-022 SHALL assert inst_addr_ok/data_addr_ok = m_addr_ok AND m_req AND the matching grant, same cycle, no added latency.
REQ-023 SHALL push owner tag (0=inst, 1=data) into an OST_DEPTH-entry tag FIFO on m_req AND m_addr_ok.
REQ-024 SHALL pop the FIFO head on m_data_ok and route it: head 0 -> inst_data_ok=1, head 1 -> data_data_ok=1, same cycle; m_rdata passes combinationally to both rdata outputs.
REQ-025 SHALL keep occupancy count 0..OST_DEPTH, width clog2(OST_DEPTH)+1; pointers wrap modulo OST_DEPTH.
REQ-026 SHALL force m_req=0 and both addr_ok=0 when count==OST_DEPTH; lock state is retained.
REQ-027 SHALL handle push and pop in one cycle with count unchanged, including at count==OST_DEPTH-1 and count==1.
REQ-028 SHALL ignore m_data_ok when count==0 (no pop, both data_ok=0).

Reset
REQ-029 SHALL on aresetn=0 immediately clear count, pointers, lock and round-robin pointer; all data_ok/addr_ok/m_req outputs 0 while in reset.
REQ-030 SHALL discard in-flight tags on reset; responses arriving after reset release are dropped per REQ-028.

Configuration
REQ-031 SHALL, with ARB_RR_EN defined, replace fixed priority by round-robin: after each accepted grant the other requester gets priority on the next contention; pointer resets to data-first. Without ARB_RR_EN, REQ-020 applies and no round-robin state exists.

Verification
REQ-032 Both req=1, m_addr_ok=1 every cycle, no ARB_RR_EN -> data accepted every cycle, inst starved; with ARB_RR_EN -> alternating D,I,D,I.
REQ-033 inst_req=1 alone, m_addr_ok=0 3 cycles, data_req rises cycle 1, m_addr_ok=1 cycle 3 -> inst_addr_ok at cycle 3, data granted cycle 4.
REQ-034 4 accepts (D,I,D,I) with no m_data_ok -> count=4, m_req=0 with reqs pending; then 4 m_data_ok with m_rdata 0x11..0x44 -> data_data_ok, inst_data_ok, data_data_ok, inst_data_ok in order with matching rdata.
REQ-035 count=4, m_data_ok=1 -> count=3 that cycle's edge, m_req=1 next cycle; simultaneous push+pop at count=3 -> count stays 3.
REQ-036 aresetn=0 asynchronously mid-burst with count=2 -> outputs 0 without clock edge; after release, stray m_data_ok -> no data_ok pulse, count=0.
